knn_vote: RTL and testbench
===========================

# knn_vote

Majority-vote classifier that sits downstream of the k-NN core and consumes its sorted neighbour label list. On `start` it snapshots the packed list of `N_Neighbour` labels, scans it sequentially, and reports the winning class label and its vote score. It is the reader for the neighbour list that the k-NN core writes. The result is exposed to the CPU-side register interface through a `busy`/`done` handshake.

## Interface

Parameters:
- `LABEL`, 8: width of one class label.
- `N_Neighbour`, 10: number of list slots; must be ≥ 1.
- `VOTE_W`, derived as $clog2(N_Neighbour*(N_Neighbour+1)/2+1): score width. This width is used in both configurations.

Ports:
- `clk`  in  1  clock; all logic rises on the posedge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  request a classification. Sampled only in IDLE.
- `n_valid`  in  $clog2(N_Neighbour+1)  number of occupied slots. Sampled with `start`.
- `Neighbour_info`  in  LABEL*N_Neighbour  packed labels. Slot j is bits [LABEL*j+LABEL-1 : LABEL*j]. Slot 0 is the nearest neighbour.
- `busy`  out  1  high while a scan is in progress (SCAN or DONE).
- `done`  out  1  one-cycle pulse when the result is valid.
- `label_out`  out  LABEL  winning label. Held until the next `done`.
- `votes_out`  out  VOTE_W  score of the winning label. Held until the next `done`.

## Operation

States:
- IDLE: waits for `start`.
- SCAN: evaluates one candidate slot per cycle.
- DONE: pulses `done`.

Start (IDLE, `start`=1):
- Latch `Neighbour_info` into a snapshot register.
- Latch `n_valid` and clamp it to `N_Neighbour`.
- Clear the candidate index `i`, best score and best label.
- Go to SCAN.

Each SCAN cycle, for candidate slot i:
- score_i = sum over valid slots j of w_j · (label_j == label_i).
- A slot j is valid when j < n_valid.
- w_j = 1 by default. See Configuration for the weighted mode.
- The comparison uses N_Neighbour parallel comparators plus an adder tree.
- Update best label and best score only if i < n_valid and score_i > best score (strictly greater).
- Ties therefore go to the lowest slot index, i.e. the nearest neighbour.

Termination:
- SCAN runs exactly N_Neighbour cycles regardless of `n_valid`. Latency is fixed.
- After slot N_Neighbour-1, go to DONE.
- DONE: copy best label and best score to `label_out`/`votes_out`, assert `done`, return to IDLE next cycle.

Boundary rules:
- `n_valid`=0: result is `label_out`=0, `votes_out`=0, still with a `done` pulse.
- `n_valid` > N_Neighbour: treated as N_Neighbour.
- `start` in SCAN or DONE is ignored. It is not queued.
- Changes on `Neighbour_info` after the start cycle have no effect on the current scan.
- `rst` mid-scan: aborts the scan immediately to IDLE with reset values on all outputs. No `done` is produced.

## Timing

Reset values: state IDLE; `busy`=0, `done`=0, `label_out`=0, `votes_out`=0; snapshot and index all 0.

Latency:
- `start` is sampled at edge k.
- `busy` is high from k through k+N_Neighbour+1.
- `done` is high for the single cycle following edge k+N_Neighbour+1. For N_Neighbour=10 that is 11 cycles after the start edge.
- `label_out`/`votes_out` change only at the edge that raises `done`.

Back-to-back operation:
- The next `start` is accepted the cycle `done` falls (state is back in IDLE).
- Minimum issue interval is N_Neighbour+2 cycles.

## Configuration

Macro `KNN_VOTE_RANK_WEIGHT_EN`:
- Defined: rank weighting, w_j = N_Neighbour − j. Nearer neighbours count more. The maximum score is N_Neighbour(N_Neighbour+1)/2.
- Undefined: plain count, w_j = 1. The maximum score is N_Neighbour.
- Latency, ports and `VOTE_W` are identical in both modes.

## Test plan

All scenarios use N_Neighbour=10 and LABEL=8.

- Reset: assert `rst` asynchronously mid-cycle. All outputs go to 0 without a clock edge. After release with `start`=0, `busy` stays 0.
- Clear majority: slots = {3,3,7,3,1,3,7,2,3,5}, `n_valid`=10, unweighted. `done` arrives 11 cycles after `start`, with `label_out`=3 and `votes_out`=5.
- Tie goes to nearest: slots = {9,4,4,9,…all 0 from slot 4}, `n_valid`=4, unweighted. Result is `label_out`=9, `votes_out`=2.
- Partial list and empty list:
  - slots = {6,2,2,2,…}, `n_valid`=1: `label_out`=6, `votes_out`=1.
  - `n_valid`=0: `label_out`=0, `votes_out`=0, with `done` still pulsing.
- Rank weighting: build with `KNN_VOTE_RANK_WEIGHT_EN`. Slots = {8,1,1,1,8,0,0,0,0,0}, `n_valid`=5. Label 8 scores 10+6=16 and label 1 scores 9+8+7=24, so `label_out`=1 and `votes_out`=24. Without the macro, the same input also gives `label_out`=1 but `votes_out`=3.
- Protocol robustness:
  - Pulse `start` during SCAN and change `Neighbour_info` mid-scan: the result matches the snapshot, and only one `done` is produced.
  - Assert `rst` at SCAN cycle 5: no `done`, outputs are 0, and a new `start` afterwards completes normally.

Source files
------------

// File: rtl/knn_vote_if.sv
// rtl/knn_vote_if.sv - request/result bundle between the CPU register side and knn_vote.
// Shared by both configurations (KNN_VOTE_RANK_WEIGHT_EN does not change any width).
interface knn_vote_if #(
   parameter int LABEL       = 8,
   parameter int N_Neighbour = 10
);
   localparam int VOTE_W = $clog2(N_Neighbour * (N_Neighbour + 1) / 2 + 1);
   localparam int NV_W   = $clog2(N_Neighbour + 1);

   logic                         start;
   logic [NV_W-1:0]              n_valid;
   logic [LABEL*N_Neighbour-1:0] Neighbour_info;
   logic                         busy;
   logic                         done;
   logic [LABEL-1:0]             label_out;
   logic [VOTE_W-1:0]            votes_out;

   modport master (
      output start, n_valid, Neighbour_info,
      input  busy, done, label_out, votes_out
   );

   modport slave (
      input  start, n_valid, Neighbour_info,
      output busy, done, label_out, votes_out
   );
endinterface

// File: rtl/knn_vote.sv
// rtl/knn_vote.sv - majority-vote classifier over a snapshot of the k-NN neighbour label list.
// Optional macro KNN_VOTE_RANK_WEIGHT_EN weights slot j by N_Neighbour-j instead of 1.
module knn_vote #(
   parameter int LABEL       = 8,
   parameter int N_Neighbour = 10
) (
   input  logic        clk,
   input  logic        rst,
   knn_vote_if.slave   bus
);
   localparam int VOTE_W = $clog2(N_Neighbour * (N_Neighbour + 1) / 2 + 1);
   localparam int NV_W   = $clog2(N_Neighbour + 1);
   localparam int IDX_W  = (N_Neighbour > 1) ? $clog2(N_Neighbour) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [LABEL-1:0]  snap [N_Neighbour];
   logic [NV_W-1:0]   n_cnt;
   logic [IDX_W-1:0]  idx;
   logic [LABEL-1:0]  best_label;
   logic [VOTE_W-1:0] best_score;
   logic [VOTE_W-1:0] score;
   logic [LABEL-1:0]  cand;
   logic [NV_W-1:0]   n_clamp;
   logic              last_idx;
   logic              cand_valid;

   assign n_clamp    = (bus.n_valid > NV_W'(N_Neighbour)) ? NV_W'(N_Neighbour) : bus.n_valid;
   assign last_idx   = (idx == IDX_W'(N_Neighbour - 1));
   assign cand_valid = (NV_W'(idx) < n_cnt);
   assign bus.busy   = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = SCAN;
         SCAN:    if (last_idx)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // One candidate per cycle, scored against every valid slot in parallel.
   always_comb begin
      score = '0;
      cand  = snap[idx];
      for (int j = 0; j < N_Neighbour; j++) begin
         if ((NV_W'(j) < n_cnt) && (snap[j] == cand)) begin
`ifdef KNN_VOTE_RANK_WEIGHT_EN
            score = score + VOTE_W'(N_Neighbour - j);
`else
            score = score + VOTE_W'(1);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j < N_Neighbour; j++) snap[j] <= '0;
         n_cnt         <= '0;
         idx           <= '0;
         best_label    <= '0;
         best_score    <= '0;
         bus.done      <= 1'b0;
         bus.label_out <= '0;
         bus.votes_out <= '0;
      end else begin
         bus.done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int j = 0; j < N_Neighbour; j++)
                     snap[j] <= bus.Neighbour_info[LABEL*j +: LABEL];
                  n_cnt      <= n_clamp;
                  idx        <= '0;
                  best_label <= '0;
                  best_score <= '0;
               end
            end
            SCAN: begin
               // Strictly greater keeps the nearest slot on ties.
               if (cand_valid && (score > best_score)) begin
                  best_label <= cand;
                  best_score <= score;
               end
               if (!last_idx) idx <= idx + IDX_W'(1);
            end
            DONE: begin
               bus.done      <= 1'b1;
               bus.label_out <= best_label;
               bus.votes_out <= best_score;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_knn_vote.sv
// tb/tb_knn_vote.sv - randomized bench for knn_vote against a histogram reference model.
// Honours KNN_VOTE_RANK_WEIGHT_EN so the model weights match the build.
module tb_knn_vote;
   localparam int LABEL = 8;
   localparam int NN    = 10;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   knn_vote_if #(.LABEL(LABEL), .N_Neighbour(NN)) bus ();

   knn_vote #(.LABEL(LABEL), .N_Neighbour(NN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Histogram of weighted votes per label; ties resolved by earliest slot.
   task automatic model(input logic [7:0] lab[NN], input int nv, output int wl, output int wv);
      int sc [256];
      int first [256];
      int n;
      int w;
      int bf;
      for (int k = 0; k < 256; k++) begin
         sc[k]    = 0;
         first[k] = -1;
      end
      n = (nv > NN) ? NN : nv;
      for (int j = 0; j < n; j++) begin
`ifdef KNN_VOTE_RANK_WEIGHT_EN
         w = NN - j;
`else
         w = 1;
`endif
         sc[lab[j]] += w;
         if (first[lab[j]] < 0) first[lab[j]] = j;
      end
      wl = 0;
      wv = 0;
      bf = NN + 1;
      for (int k = 0; k < 256; k++) begin
         if (sc[k] > 0 && (sc[k] > wv || (sc[k] == wv && first[k] < bf))) begin
            wl = k;
            wv = sc[k];
            bf = first[k];
         end
      end
   endtask

   task automatic run_case(input logic [7:0] lab[NN], input int nv, input bit disturb,
                           input string tag, output int gl, output int gv);
      int cnt;
      int extra;
      int el;
      int ev;
      @(negedge clk);
      for (int j = 0; j < NN; j++) bus.Neighbour_info[LABEL*j +: LABEL] = lab[j];
      bus.n_valid = 4'(nv);
      bus.start   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, "_busy"}, bus.busy, 1);
      cnt = 0;
      while (!bus.done && cnt < 40) begin
         if (disturb && cnt == 3) begin
            bus.start          = 1'b1;
            bus.Neighbour_info = {$urandom, $urandom, $urandom};
            bus.n_valid        = 4'($urandom_range(0, 15));
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clk);
         cnt++;
      end
      bus.start = 1'b0;
      chk({tag, "_latency"}, cnt, 11);
      model(lab, nv, el, ev);
      gl = int'(bus.label_out);
      gv = int'(bus.votes_out);
      chk({tag, "_label"}, gl, el);
      chk({tag, "_votes"}, gv, ev);
      @(negedge clk);
      chk({tag, "_done_fall"}, bus.done, 0);
      chk({tag, "_idle"}, bus.busy, 0);
      if (disturb) begin
         extra = 0;
         for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (bus.done) extra++;
         end
         chk({tag, "_single_done"}, extra, 0);
      end
   endtask

   initial begin
      logic [7:0] lab [NN];
      int gl;
      int gv;
      int dones;
      n_cmp              = 0;
      n_err              = 0;
      rst                = 1'b1;
      bus.start          = 1'b0;
      bus.n_valid        = '0;
      bus.Neighbour_info = '0;

      #12;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_label", bus.label_out, 0);
      chk("rst_votes", bus.votes_out, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_busy", bus.busy, 0);

      lab = '{3, 3, 7, 3, 1, 3, 7, 2, 3, 5};
      run_case(lab, 10, 1'b0, "majority", gl, gv);
`ifndef KNN_VOTE_RANK_WEIGHT_EN
      chk("majority_const_label", gl, 3);
      chk("majority_const_votes", gv, 5);
`endif

      lab = '{9, 4, 4, 9, 0, 0, 0, 0, 0, 0};
      run_case(lab, 4, 1'b0, "tie", gl, gv);
      chk("tie_const_label", gl, 9);

      lab = '{6, 2, 2, 2, 2, 2, 2, 2, 2, 2};
      run_case(lab, 1, 1'b0, "partial", gl, gv);
      chk("partial_const_label", gl, 6);

      run_case(lab, 0, 1'b0, "empty", gl, gv);
      chk("empty_const_label", gl, 0);
      chk("empty_const_votes", gv, 0);

      lab = '{8, 1, 1, 1, 8, 0, 0, 0, 0, 0};
      run_case(lab, 5, 1'b0, "rank", gl, gv);
      chk("rank_const_label", gl, 1);
`ifdef KNN_VOTE_RANK_WEIGHT_EN
      chk("rank_const_votes", gv, 24);
`else
      chk("rank_const_votes", gv, 3);
`endif

      lab = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 5};
      run_case(lab, 15, 1'b0, "clamp", gl, gv);

      lab = '{2, 7, 7, 2, 7, 4, 4, 4, 4, 1};
      run_case(lab, 10, 1'b1, "disturb", gl, gv);

      // Asynchronous abort at SCAN cycle 5, outputs currently non-zero.
      @(negedge clk);
      for (int j = 0; j < NN; j++) bus.Neighbour_info[LABEL*j +: LABEL] = 8'(j + 1);
      bus.n_valid = 4'd10;
      bus.start   = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_label", bus.label_out, 0);
      chk("abort_votes", bus.votes_out, 0);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_no_done", dones, 0);
      lab = '{4, 0, 4, 0, 4, 0, 0, 9, 9, 9};
      run_case(lab, 8, 1'b0, "after_abort", gl, gv);

      for (int r = 0; r < 40; r++) begin
         for (int j = 0; j < NN; j++) lab[j] = 8'($urandom_range(0, 3));
         run_case(lab, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand", gl, gv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
